// File: rtl/boot_run_pkg.sv
// Shared types and default widths for the boot/run supervisor.
package boot_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        READ,
        DONE
    } state_t;

    localparam logic TGT_IM = 1'b0;
    localparam logic TGT_DM = 1'b1;

    localparam int DEF_ADDR_W      = 7;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_CYC_W       = 16;
    localparam int DEF_HALT_REPEAT = 4;
    localparam int HALT_CNT_W      = 4;

endpackage

// File: rtl/boot_run_ctrl_if.sv
// Program load stream: one beat per valid&ready, steered to IM or DM.
interface boot_run_ctrl_if
    import boot_run_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              ld_valid;
    logic              ld_ready;
    logic              ld_target;
    logic              ld_last;
    logic [DATA_W-1:0] ld_data;

    modport master (
        output ld_valid,
        output ld_target,
        output ld_last,
        output ld_data,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_target,
        input  ld_last,
        input  ld_data,
        output ld_ready
    );

endinterface

// File: rtl/halt_detector.sv
// Flags a halted CPU once the same PC has been seen on HALT_REPEAT consecutive enabled cycles.
module halt_detector
    import boot_run_pkg::*;
#(
    parameter int PC_W        = DEF_DATA_W,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            halt_o
);

    logic [PC_W-1:0]       prev_q;
    logic                  prev_vld_q;
    logic [HALT_CNT_W-1:0] eq_cnt_q;
    logic                  same;

    // eq_cnt_q counts consecutive equal comparisons; HALT_REPEAT samples need HALT_REPEAT-1 of them.
    assign same   = prev_vld_q && (pc_i == prev_q);
    assign halt_o = enable_i && same && (eq_cnt_q >= HALT_CNT_W'(HALT_REPEAT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            eq_cnt_q   <= '0;
        end else if (!enable_i) begin
            prev_vld_q <= 1'b0;
            eq_cnt_q   <= '0;
        end else begin
            prev_q     <= pc_i;
            prev_vld_q <= 1'b1;
            if (!same)
                eq_cnt_q <= '0;
            else if (eq_cnt_q != {HALT_CNT_W{1'b1}})
                eq_cnt_q <= eq_cnt_q + HALT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/boot_run_ctrl.sv
// Program loader and run supervisor for the pipelined MIPS core.
// Defining TRACE_EN adds a registered per-cycle PC trace during RUN.
module boot_run_ctrl
    import boot_run_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CYC_W       = DEF_CYC_W,
    parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic              clk,
    input  logic              rst_n,
    boot_run_ctrl_if.slave    ld,
    input  logic              start_i,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [DATA_W-1:0] im_wdata_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    output logic [ADDR_W-1:0] dm_raddr_o,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              cpu_rst_o,
    input  logic [DATA_W-1:0] cpu_pc_i,
    input  logic [CYC_W-1:0]  cycle_limit_i,
    input  logic [ADDR_W-1:0] result_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              load_err_o,
    output logic [CYC_W-1:0]  cycles_o,
    output logic [DATA_W-1:0] result_o,
    output logic              trace_valid_o,
    output logic [DATA_W-1:0] trace_pc_o
);

    // state | meaning
    // IDLE  | after reset, CPU held, waiting for start
    // LOAD  | accepting load beats into IM/DM, CPU held
    // RUN   | CPU released, counting cycles, watching for halt/limit
    // READ  | CPU held, result word read from DM (one wait cycle)
    // DONE  | result/cycles/timeout held, waiting for start

    localparam int CNT_W = ADDR_W + 1;

    state_t             state_q;
    logic [CNT_W-1:0]   im_cnt_q, dm_cnt_q;
    logic               im_we_q, dm_we_q;
    logic [ADDR_W-1:0]  im_addr_q, dm_addr_q, dm_raddr_q;
    logic [DATA_W-1:0]  im_wdata_q, dm_wdata_q, result_q;
    logic               ld_ready_q, cpu_rst_q, busy_q, done_q;
    logic               timeout_q, load_err_q, rd_wait_q;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic               beat, halt, limit_hit;

    assign beat      = ld.ld_valid && ld_ready_q;
    assign cycles_d  = (&cycles_q) ? cycles_q : cycles_q + CYC_W'(1);
    assign limit_hit = (cycle_limit_i != '0) && (cycles_d == cycle_limit_i);

    halt_detector #(
        .PC_W        (DATA_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (state_q == RUN),
        .pc_i     (cpu_pc_i),
        .halt_o   (halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            im_cnt_q   <= '0;
            dm_cnt_q   <= '0;
            im_we_q    <= 1'b0;
            dm_we_q    <= 1'b0;
            im_addr_q  <= '0;
            dm_addr_q  <= '0;
            dm_raddr_q <= '0;
            im_wdata_q <= '0;
            dm_wdata_q <= '0;
            result_q   <= '0;
            ld_ready_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            load_err_q <= 1'b0;
            rd_wait_q  <= 1'b0;
            cycles_q   <= '0;
        end else begin
            im_we_q <= 1'b0;
            dm_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= LOAD;
                        im_cnt_q   <= '0;
                        dm_cnt_q   <= '0;
                        cycles_q   <= '0;
                        timeout_q  <= 1'b0;
                        load_err_q <= 1'b0;
                        result_q   <= '0;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        // Counter MSB set means the target is full: accept and drop the beat.
                        if (ld.ld_target == TGT_IM) begin
                            if (!im_cnt_q[ADDR_W]) begin
                                im_we_q    <= 1'b1;
                                im_addr_q  <= im_cnt_q[ADDR_W-1:0];
                                im_wdata_q <= ld.ld_data;
                                im_cnt_q   <= im_cnt_q + CNT_W'(1);
                            end else begin
                                load_err_q <= 1'b1;
                            end
                        end else begin
                            if (!dm_cnt_q[ADDR_W]) begin
                                dm_we_q    <= 1'b1;
                                dm_addr_q  <= dm_cnt_q[ADDR_W-1:0];
                                dm_wdata_q <= ld.ld_data;
                                dm_cnt_q   <= dm_cnt_q + CNT_W'(1);
                            end else begin
                                load_err_q <= 1'b1;
                            end
                        end
                        if (ld.ld_last) begin
                            state_q    <= RUN;
                            ld_ready_q <= 1'b0;
                            cpu_rst_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cycles_q <= cycles_d;
                    if (halt || limit_hit) begin
                        state_q    <= READ;
                        timeout_q  <= !halt;
                        cpu_rst_q  <= 1'b1;
                        dm_raddr_q <= result_addr_i;
                        rd_wait_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_wait_q) begin
                        rd_wait_q <= 1'b0;
                    end else begin
                        result_q <= dm_rdata_i;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ld.ld_ready = ld_ready_q;
    assign im_we_o     = im_we_q;
    assign im_addr_o   = im_addr_q;
    assign im_wdata_o  = im_wdata_q;
    assign dm_we_o     = dm_we_q;
    assign dm_addr_o   = dm_addr_q;
    assign dm_wdata_o  = dm_wdata_q;
    assign dm_raddr_o  = dm_raddr_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign load_err_o  = load_err_q;
    assign cycles_o    = cycles_q;
    assign result_o    = result_q;

`ifdef TRACE_EN
    logic              trace_valid_q;
    logic [DATA_W-1:0] trace_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
        end else begin
            trace_valid_q <= (state_q == RUN);
            trace_pc_q    <= (state_q == RUN) ? cpu_pc_i : '0;
        end
    end

    assign trace_valid_o = trace_valid_q;
    assign trace_pc_o    = trace_pc_q;
`else
    assign trace_valid_o = 1'b0;
    assign trace_pc_o    = '0;
`endif

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Self-checking bench for boot_run_ctrl: directed scenarios plus randomized programs vs. a behavioural model.
module tb_boot_run_ctrl;
    import boot_run_pkg::*;

    localparam int AW = 7, DW = 32, CW = 16, HR = 4, DEPTH = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start;
    logic          im_we, dm_we, cpu_rst, busy, done, timeout, load_err, trace_valid;
    logic [AW-1:0] im_addr, dm_addr, dm_raddr, result_addr;
    logic [DW-1:0] im_wdata, dm_wdata, dm_rdata, cpu_pc, result, trace_pc;
    logic [CW-1:0] cycle_limit, cycles;

    boot_run_ctrl_if #(.DATA_W(DW)) ld_if ();

    boot_run_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CYC_W(CW), .HALT_REPEAT(HR)) dut (
        .clk(clk), .rst_n(rst_n), .ld(ld_if), .start_i(start),
        .im_we_o(im_we), .im_addr_o(im_addr), .im_wdata_o(im_wdata),
        .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
        .dm_raddr_o(dm_raddr), .dm_rdata_i(dm_rdata), .cpu_rst_o(cpu_rst),
        .cpu_pc_i(cpu_pc), .cycle_limit_i(cycle_limit), .result_addr_i(result_addr),
        .busy_o(busy), .done_o(done), .timeout_o(timeout), .load_err_o(load_err),
        .cycles_o(cycles), .result_o(result), .trace_valid_o(trace_valid), .trace_pc_o(trace_pc)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural CPU: a PC script replayed one entry per RUN cycle; the last entry repeats forever.
    logic [31:0] pc_seq[$];

    function automatic logic [31:0] pc_at(input int i);
        if (i < pc_seq.size()) return pc_seq[i];
        return pc_seq[pc_seq.size()-1];
    endfunction

    // First RUN cycle (1-based) on which the PC has been identical for HR consecutive cycles.
    function automatic int halt_cycle();
        int run = 1;
        for (int i = 1; i < 4000; i++) begin
            run = (pc_at(i) == pc_at(i-1)) ? run + 1 : 1;
            if (run >= HR) return i + 1;
        end
        return 1 << 20;
    endfunction

    // Memories the DUT loads and reads back from
    logic [DW-1:0] im_mem[DEPTH];
    logic [DW-1:0] dm_mem[DEPTH];
    int  im_wr_cnt = 0, dm_wr_cnt = 0, order_err = 0;
    int  im_base = 0, dm_base = 0;
    bit  gcd_mode = 1'b0;

    always @(posedge clk) begin
        if (im_we) begin
            if (int'(im_addr) != im_wr_cnt - im_base) order_err++;
            im_mem[im_addr] <= im_wdata;
            im_wr_cnt++;
        end
        if (dm_we) begin
            if (int'(dm_addr) != dm_wr_cnt - dm_base) order_err++;
            dm_mem[dm_addr] <= dm_wdata;
            dm_wr_cnt++;
        end
        if (gcd_mode && !cpu_rst) dm_mem[2] <= gcd(dm_mem[0], dm_mem[1]);
        dm_rdata <= dm_mem[dm_raddr];
    end

    int run_idx = 0, tr_idx = 0, tr_err = 0;

    always @(negedge clk) begin
        if (trace_valid) begin
            if (trace_pc != pc_at(tr_idx)) tr_err++;
            tr_idx++;
        end else if (ld_if.ld_ready) begin
            tr_idx = 0;
        end
        if (!cpu_rst) begin
            cpu_pc = pc_at(run_idx);
            run_idx++;
        end else if (ld_if.ld_ready) begin
            run_idx = 0;
        end
    end

    logic [DW-1:0] exp_im[DEPTH];
    logic [DW-1:0] exp_dm[DEPTH];
    logic [DW-1:0] dm_init[$];
    bit exp_err;
    int n_im_wr, n_dm_wr, ord_base, tr_base;

    task automatic send_beat(input bit tgt, input logic [DW-1:0] d, input bit last);
        int n = 0;
        ld_if.ld_valid  = 1'b1;
        ld_if.ld_target = tgt;
        ld_if.ld_data   = d;
        ld_if.ld_last   = last;
        while (!ld_if.ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ld_ready_wait", ld_if.ld_ready, 1);
        @(negedge clk);
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
        if (!last && $urandom_range(3, 0) == 0) @(negedge clk);
    endtask

    task automatic load_prog(input int n_im, input int n_dm, input bit shuffle);
        bit          tq[$];
        logic [31:0] dq[$];
        int          ci = 0, cd = 0, k = 0;
        bit          tmp;
        for (int i = 0; i < n_im; i++) tq.push_back(TGT_IM);
        for (int i = 0; i < n_dm; i++) tq.push_back(TGT_DM);
        if (shuffle)
            for (int i = tq.size() - 1; i > 0; i--) begin
                int j = $urandom_range(i, 0);
                tmp = tq[i]; tq[i] = tq[j]; tq[j] = tmp;
            end
        exp_err = 1'b0;
        foreach (tq[i]) begin
            logic [31:0] d = $urandom;
            if (tq[i] == TGT_DM && k < dm_init.size()) d = dm_init[k++];
            dq.push_back(d);
            if (tq[i] == TGT_IM) begin
                if (ci < DEPTH) exp_im[ci] = d; else exp_err = 1'b1;
                ci++;
            end else begin
                if (cd < DEPTH) exp_dm[cd] = d; else exp_err = 1'b1;
                cd++;
            end
        end
        n_im_wr  = (n_im < DEPTH) ? n_im : DEPTH;
        n_dm_wr  = (n_dm < DEPTH) ? n_dm : DEPTH;
        im_base  = im_wr_cnt;
        dm_base  = dm_wr_cnt;
        ord_base = order_err;
        tr_base  = tr_err;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_done_clr", done, 0);
        chk("start_busy", busy, 1);
        chk("start_cycles_clr", cycles, 0);
        chk("start_result_clr", result, 0);
        chk("start_flags_clr", {timeout, load_err}, 0);
        foreach (tq[i]) send_beat(tq[i], dq[i], i == tq.size() - 1);
        chk("cpu_rst_release", cpu_rst, 0);
    endtask

    task automatic finish_prog(input bit poke);
        int kh, ecyc, n = 0, mm = 0;
        bit eto, poked = 1'b0;
        logic [31:0] eres;
        kh = halt_cycle();
        if (cycle_limit != 0 && int'(cycle_limit) < kh) begin
            ecyc = int'(cycle_limit); eto = 1'b1;
        end else begin
            ecyc = kh; eto = 1'b0;
        end
        eres = (gcd_mode && result_addr == 2) ? gcd(exp_dm[0], exp_dm[1]) : exp_dm[result_addr];
        while (!done && n < 6000) begin
            if (poke && !poked && !cpu_rst && n >= 2) begin
                start = 1'b1;
                poked = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n++;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk("done", done, 1);
        chk("busy_idle", busy, 0);
        chk("cpu_rst_held", cpu_rst, 1);
        chk("cycles", cycles, ecyc);
        chk("run_len", run_idx, ecyc);
        chk("timeout", timeout, eto);
        chk("load_err", load_err, exp_err);
        chk("dm_raddr", dm_raddr, result_addr);
        chk("result", result, eres);
        chk("im_writes", im_wr_cnt - im_base, n_im_wr);
        chk("dm_writes", dm_wr_cnt - dm_base, n_dm_wr);
        chk("write_order", order_err - ord_base, 0);
        for (int i = 0; i < n_im_wr; i++) if (im_mem[i] !== exp_im[i]) mm++;
        for (int i = 0; i < n_dm_wr; i++) if (dm_mem[i] !== exp_dm[i] && !(gcd_mode && i == 2)) mm++;
        chk("mem_contents", mm, 0);
`ifdef TRACE_EN
        chk("trace_count", tr_idx, ecyc);
        chk("trace_pc", tr_err - tr_base, 0);
`else
        chk("trace_count", tr_idx, 0);
`endif
        if (gcd_mode) exp_dm[2] = eres;
    endtask

    initial begin
        int n;
        start = 1'b0;
        cpu_pc = '0;
        cycle_limit = '0;
        result_addr = '0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_target = 1'b0;
        ld_if.ld_last = 1'b0;
        ld_if.ld_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_ready", ld_if.ld_ready, 0);
        chk("rst_flags", {busy, done, timeout, load_err, im_we, dm_we}, 0);
        chk("rst_counts", {cycles, result}, 0);
        chk("rst_addrs", {im_addr, dm_addr, dm_raddr, im_wdata, dm_wdata}, 0);
        chk("rst_trace", {trace_valid, trace_pc}, 0);

        // gcd program: 51 IM beats, DM {33,22,0,1}, j-to-self after 11 sequential PCs
        pc_seq = {};
        for (int i = 0; i <= 11; i++) pc_seq.push_back(32'(i * 4));
        gcd_mode = 1'b1;
        dm_init = {32'd33, 32'd22, 32'd0, 32'd1};
        cycle_limit = '0;
        result_addr = 7'd2;
        load_prog(51, 4, 1'b0);
        finish_prog(1'b0);
        gcd_mode = 1'b0;
        dm_init = {};

        // Infinite 0/4 loop stopped by the cycle limit
        pc_seq = {};
        for (int i = 0; i < 300; i++) pc_seq.push_back(32'((i % 2) * 4));
        cycle_limit = 16'd115;
        result_addr = 7'd1;
        load_prog(8, 2, 1'b1);
        finish_prog(1'b0);

        // IM overflow: 130 beats, last two dropped
        pc_seq = {32'd0, 32'd4, 32'd8};
        cycle_limit = '0;
        result_addr = 7'd0;
        load_prog(130, 0, 1'b0);
        finish_prog(1'b0);

        // Halt and limit on the same cycle: halt wins
        pc_seq = {32'd0, 32'd4};
        cycle_limit = 16'd5;
        result_addr = 7'd1;
        load_prog(3, 2, 1'b1);
        finish_prog(1'b1);

        for (int t = 0; t < 10; t++) begin
            int len, kh, nd;
            logic [31:0] v;
            len = $urandom_range(40, 0);
            pc_seq = {};
            for (int i = 0; i < len; i++) pc_seq.push_back(32'(4 * $urandom_range(2, 0)));
            v = 32'(4 * $urandom_range(20, 3));
            for (int i = 0; i < HR; i++) pc_seq.push_back(v);
            kh = halt_cycle();
            case ($urandom_range(3, 0))
                0: cycle_limit = '0;
                1: cycle_limit = CW'($urandom_range(kh, 1));
                2: cycle_limit = CW'(kh);
                default: cycle_limit = CW'(kh + 3);
            endcase
            nd = $urandom_range(8, 1);
            result_addr = AW'($urandom_range(nd - 1, 0));
            load_prog($urandom_range(135, 1), nd, 1'b1);
            finish_prog(t[0]);
        end

        // Asynchronous reset during RUN, then a clean reload from address 0
        pc_seq = {};
        for (int i = 0; i < 300; i++) pc_seq.push_back(32'((i % 2) * 4));
        cycle_limit = '0;
        load_prog(5, 1, 1'b1);
        n = 0;
        while (run_idx < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_run", run_idx >= 20, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cpu_rst", cpu_rst, 1);
        chk("abort_done_busy", {done, busy}, 0);
        chk("abort_cycles", cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", {busy, ld_if.ld_ready, cpu_rst}, 3'b001);
        pc_seq = {32'd8, 32'd12, 32'd16};
        result_addr = 7'd2;
        load_prog(20, 3, 1'b1);
        finish_prog(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
